// File: rtl/fadd_wb.sv
// rtl/fadd_wb.sv - writeback result FIFO after the FP adder with sticky exception flags
module fadd_wb #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_y,
    input  logic                       in_ovf,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_y,
    output logic                       out_ovf,
    output logic [TAG_W-1:0]           out_tag,
    output logic [2:0]                 flags,
    input  logic                       clear_flags,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]      mem_y   [DEPTH];
    logic             mem_ovf [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          accept;
    logic          pop;
    logic          nan_set;
    logic          inf_set;

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_y   = mem_y[rd_ptr];
    assign out_ovf = mem_ovf[rd_ptr];
    assign out_tag = mem_tag[rd_ptr];

    assign nan_set = (in_y[30:23] == 8'hFF) && (in_y[22:0] != 23'd0);
    assign inf_set = (in_y[30:23] == 8'hFF) && (in_y[22:0] == 23'd0);

    // Storage is deliberately left unreset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_y[wr_ptr]   <= in_y;
            mem_ovf[wr_ptr] <= in_ovf;
            mem_tag[wr_ptr] <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            flags  <= 3'b000;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A new exception in the same cycle as a clear survives the clear.
            flags <= (clear_flags ? 3'b000 : flags)
                   | (accept ? {nan_set, inf_set, in_ovf} : 3'b000);
        end
    end
endmodule

// File: doc/fadd_wb.md
Name: fadd_wb

Overview:
- Writeback/result buffer directly downstream of the combinational single-precision adder (fadd).
- Captures each adder result (y, ovf) with an issuer tag into a small FIFO and presents results to the register-file writeback port over a valid/ready handshake.
- Maintains sticky FP exception flags (overflow, NaN result, infinity result) for the CSR block.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
TAG_W, 6, width of destination-register/issue tag

Ports:
clk  input  1  clock; all state updates on rising edge
rstn  input  1  synchronous active-low reset
in_valid  input  1  adder result present this cycle
in_ready  output  1  buffer can accept (= not full)
in_y  input  32  adder result word
in_ovf  input  1  adder overflow indication
in_tag  input  TAG_W  tag travelling with the operation
out_valid  output  1  head entry available
out_ready  input  1  consumer takes head entry
out_y  output  32  head result word
out_ovf  output  1  head entry overflow bit
out_tag  output  TAG_W  head entry tag
flags  output  3  sticky {nan, inf, ovf}
clear_flags  input  1  synchronous clear of flags
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rstn=0 at a clock edge): write/read pointers=0, count=0, flags=0, out_valid=0, in_ready=1. Storage array is not reset. rstn has priority over every other input, including mid-stream; all queued entries are discarded.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count != DEPTH). Purely from state; no same-cycle pop bypass. When full, in_ready=0 even if out_ready=1.
- out_valid = (count != 0). out_y/out_ovf/out_tag show the head entry. They are don't-care when out_valid=0, and the bench must not check them then.
- Latency: an entry accepted at edge N is visible with out_valid=1 after edge N (registered). There is no combinational in->out path.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count: +1 on accept only, -1 on pop only, unchanged on simultaneous accept and pop. Never exceeds DEPTH and never underflows, because handshakes are gated by in_ready/out_valid.
- Ordering: strict FIFO. Tag, y and ovf stay bound to the same entry.
- Flag classification on accepted word y, where e=y[30:23] and m=y[22:0]:
  - nan_set = (e==255) & (m!=0)
  - inf_set = (e==255) & (m==0)
  - ovf_set = in_ovf
- Flags update each cycle as flags_next = (clear_flags ? 0 : flags) | (accept ? {nan_set, inf_set, ovf_set} : 0). A set in the same cycle as a clear wins. Flags are not affected by pop.
- in_valid while in_ready=0: data is ignored, no flag update, and the producer holds the data.
- out_ready while out_valid=0: no effect.

Test Plan:
1. Reset, then push y=0x3F800000 tag=5 ovf=0 -> next cycle out_valid=1, out_y=0x3F800000, out_tag=5, count=1, flags=000. Pop -> count=0, out_valid=0.
2. Push 4 entries (tags 1..4) with out_ready=0 -> count=4, in_ready=0. A 5th push (tag 9) is ignored. Drain -> tags 1,2,3,4 in order, then in_ready=1. Refill 3 entries to exercise pointer wrap, and check order.
3. Full buffer, in_valid=1 and out_ready=1 same cycle -> pop only, count 4->3, pushed word not stored. At count=2 with simultaneous push and pop -> count stays 2 and the pushed entry appears after the existing ones.
4. Accepted y=0x7F800000 ovf=1 -> flags=011. Accepted y=0x7FC00000 -> flags=111. clear_flags=1 with no accept -> 000. clear_flags=1 in same cycle as accepting 0xFF800000 -> flags=010.
5. Rejected push (full) of y=0x7FC00000 -> flags unchanged at 000.
6. rstn=0 while holding 3 entries and flags=001 -> count=0, out_valid=0, flags=000, in_ready=1 after the edge. The first post-reset push appears at the head alone.
